// File: rtl/stack_queue_buf_pkg.sv
// stack_queue_buf_pkg: shared FSM state type and default geometry for the stack/queue buffer
package stack_queue_buf_pkg;
  typedef enum logic {BUILD, DRAIN} state_t;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 16;
endpackage

// File: rtl/stack_queue_buf_if.sv
// stack_queue_buf_if: request/response bundle; master drives locIn/push/pop/done, slave returns locOut/outValid/status
interface stack_queue_buf_if
  import stack_queue_buf_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
);
  logic [WIDTH-1:0]         locIn;
  logic                     push;
  logic                     pop;
  logic                     done;
  logic [WIDTH-1:0]         locOut;
  logic                     outValid;
  logic                     empStck;
  logic                     full;
  logic [$clog2(DEPTH):0]   count;
  logic                     draining;
  logic                     err;
  modport master (output locIn, push, pop, done,
                  input  locOut, outValid, empStck, full, count, draining, err);
  modport slave  (input  locIn, push, pop, done,
                  output locOut, outValid, empStck, full, count, draining, err);
endinterface

// File: rtl/sqb_mem.sv
// sqb_mem: WIDTH x DEPTH storage, one synchronous write port and one asynchronous read port
//   clk: write clock; we/waddr/wdata: write port; raddr/rdata: combinational read port
module sqb_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);
  logic [WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk) if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/stack_queue_buf.sv
// stack_queue_buf: circular buffer that pops LIFO while building and LIFO/FIFO (DRAIN_FIFO) while draining
//   clk: rising-edge clock; rst: asynchronous active-low reset
//   bus (slave): locIn/push/pop/done in; locOut/outValid/empStck/full/count/draining/err out
module stack_queue_buf
  import stack_queue_buf_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int DRAIN_FIFO = 1
) (
  input  logic             clk,
  input  logic             rst,
  stack_queue_buf_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  state_t           state, state_n;
  logic [PW-1:0]    head, tail, head_n, tail_n, top, waddr, raddr;
  logic [CW-1:0]    cnt, cnt_n;
  logic [WIDTH-1:0] rdata, loc_out;
  logic             we, rd, err, err_n, out_valid, emp, full, draining, is_empty, is_full;
  sqb_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_mem (
    .clk(clk), .we(we), .waddr(waddr), .wdata(bus.locIn), .raddr(raddr), .rdata(rdata)
  );
  always_comb begin
    top      = tail - 1'b1;
    is_empty = cnt == '0;
    is_full  = cnt == CW'(DEPTH);
    state_n  = state;
    head_n   = head;
    tail_n   = tail;
    cnt_n    = cnt;
    err_n    = err;
    we       = 1'b0;
    rd       = 1'b0;
    waddr    = tail;
    raddr    = top;
    if (state == BUILD) begin
      if (bus.push && bus.pop && !is_empty) begin
        // swap: return the current top and overwrite that slot in place
        rd    = 1'b1;
        we    = 1'b1;
        waddr = top;
      end else if (bus.push) begin
        if (is_full) err_n = 1'b1;
        else begin
          we     = 1'b1;
          tail_n = tail + 1'b1;
          cnt_n  = cnt + 1'b1;
        end
        if (bus.pop) err_n = 1'b1;
      end else if (bus.pop) begin
        if (is_empty) err_n = 1'b1;
        else begin
          rd     = 1'b1;
          tail_n = top;
          cnt_n  = cnt - 1'b1;
        end
      end
      if (bus.done && cnt_n != '0) state_n = DRAIN;
    end else begin
      if (bus.push) err_n = 1'b1;
      if (bus.pop) begin
        if (is_empty) err_n = 1'b1;
        else begin
          rd    = 1'b1;
          cnt_n = cnt - 1'b1;
          if (DRAIN_FIFO != 0) begin
            raddr  = head;
            head_n = head + 1'b1;
          end else tail_n = top;
          if (cnt == CW'(1)) state_n = BUILD;
        end
      end
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= BUILD;
      head      <= '0;
      tail      <= '0;
      cnt       <= '0;
      loc_out   <= '0;
      out_valid <= 1'b0;
      err       <= 1'b0;
      emp       <= 1'b1;
      full      <= 1'b0;
      draining  <= 1'b0;
    end else begin
      state     <= state_n;
      head      <= head_n;
      tail      <= tail_n;
      cnt       <= cnt_n;
      loc_out   <= rd ? rdata : loc_out;
      out_valid <= rd;
      err       <= err_n;
      emp       <= cnt_n == '0;
      full      <= cnt_n == CW'(DEPTH);
      draining  <= state_n == DRAIN;
    end
  end
  assign bus.locOut   = loc_out;
  assign bus.outValid = out_valid;
  assign bus.empStck  = emp;
  assign bus.full     = full;
  assign bus.count    = cnt;
  assign bus.draining = draining;
  assign bus.err      = err;
endmodule

// File: tb/tb_stack_queue_buf.sv
// tb_stack_queue_buf: directed bench driving a FIFO-drain and a LIFO-drain instance with identical stimulus
module tb_stack_queue_buf;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] loc_in = '0;
  logic       push = 1'b0, pop = 1'b0, done = 1'b0;
  int         checks = 0, passed = 0;
  always #5 clk = ~clk;
  stack_queue_buf_if #(.WIDTH(8), .DEPTH(16)) fa ();
  stack_queue_buf_if #(.WIDTH(8), .DEPTH(16)) lb ();
  assign fa.locIn = loc_in;
  assign fa.push  = push;
  assign fa.pop   = pop;
  assign fa.done  = done;
  assign lb.locIn = loc_in;
  assign lb.push  = push;
  assign lb.pop   = pop;
  assign lb.done  = done;
  stack_queue_buf #(.WIDTH(8), .DEPTH(16), .DRAIN_FIFO(1)) dut_f (.clk(clk), .rst(rst), .bus(fa.slave));
  stack_queue_buf #(.WIDTH(8), .DEPTH(16), .DRAIN_FIFO(0)) dut_l (.clk(clk), .rst(rst), .bus(lb.slave));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask
  task automatic step(input logic ps, input logic pp, input logic dn, input logic [7:0] v);
    loc_in = v;
    push   = ps;
    pop    = pp;
    done   = dn;
    @(posedge clk);
    #1;
    push = 1'b0;
    pop  = 1'b0;
    done = 1'b0;
  endtask
  task automatic do_reset;
    rst = 1'b0;
    #3;
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask
  initial begin
    #12;
    chk("rst_emp", 32'(fa.empStck), 1);
    chk("rst_full", 32'(fa.full), 0);
    chk("rst_count", 32'(fa.count), 0);
    chk("rst_drain", 32'(fa.draining), 0);
    chk("rst_err", 32'(fa.err), 0);
    chk("rst_loc", 32'(fa.locOut), 0);
    chk("rst_valid", 32'(fa.outValid), 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    // build/drain order for both drain modes
    step(1, 0, 0, 8'h40);
    step(1, 0, 0, 8'h01);
    step(0, 1, 0, 8'h00);
    chk("seq_pop_loc", 32'(fa.locOut), 32'h01);
    chk("seq_pop_valid", 32'(fa.outValid), 1);
    chk("seq_pop_count", 32'(fa.count), 1);
    step(0, 0, 0, 8'h00);
    chk("seq_valid_drop", 32'(fa.outValid), 0);
    chk("seq_loc_hold", 32'(fa.locOut), 32'h01);
    step(1, 0, 0, 8'h40);
    step(1, 0, 0, 8'hA3);
    step(0, 0, 1, 8'h00);
    chk("seq_draining", 32'(fa.draining), 1);
    chk("seq_count3", 32'(fa.count), 3);
    step(0, 1, 0, 8'h00);
    chk("fifo_pop0", 32'(fa.locOut), 32'h40);
    chk("lifo_pop0", 32'(lb.locOut), 32'hA3);
    step(0, 1, 0, 8'h00);
    chk("fifo_pop1", 32'(fa.locOut), 32'h40);
    chk("lifo_pop1", 32'(lb.locOut), 32'h40);
    chk("drain_still", 32'(fa.draining), 1);
    step(0, 1, 0, 8'h00);
    chk("fifo_pop2", 32'(fa.locOut), 32'hA3);
    chk("lifo_pop2", 32'(lb.locOut), 32'h40);
    chk("fifo_valid2", 32'(fa.outValid), 1);
    chk("drain_emp", 32'(fa.empStck), 1);
    chk("drain_exit", 32'(fa.draining), 0);
    chk("lifo_exit", 32'(lb.draining), 0);
    chk("seq_no_err", 32'(fa.err), 0);
    // pop and done on empty
    step(0, 1, 0, 8'h00);
    chk("empty_pop_err", 32'(fa.err), 1);
    chk("empty_pop_valid", 32'(fa.outValid), 0);
    chk("empty_pop_loc", 32'(fa.locOut), 32'hA3);
    chk("empty_pop_loc_l", 32'(lb.locOut), 32'h40);
    step(0, 0, 1, 8'h00);
    chk("empty_done", 32'(fa.draining), 0);
    // simultaneous push + pop
    do_reset();
    step(1, 0, 0, 8'h11);
    step(1, 0, 0, 8'h22);
    step(1, 1, 0, 8'h33);
    chk("swap_loc", 32'(fa.locOut), 32'h22);
    chk("swap_valid", 32'(fa.outValid), 1);
    chk("swap_count", 32'(fa.count), 2);
    step(0, 1, 0, 8'h00);
    chk("swap_next", 32'(fa.locOut), 32'h33);
    step(0, 1, 0, 8'h00);
    chk("swap_last", 32'(fa.locOut), 32'h11);
    chk("swap_err", 32'(fa.err), 0);
    // fill, overflow, LIFO unwind
    do_reset();
    for (int i = 0; i < 16; i++) step(1, 0, 0, 8'(i));
    chk("fill_full", 32'(fa.full), 1);
    chk("fill_count", 32'(fa.count), 16);
    chk("fill_err0", 32'(fa.err), 0);
    step(1, 0, 0, 8'hFF);
    chk("ovf_err", 32'(fa.err), 1);
    chk("ovf_count", 32'(fa.count), 16);
    for (int i = 15; i >= 0; i--) begin
      step(0, 1, 0, 8'h00);
      chk("unwind", 32'(fa.locOut), 32'(i));
    end
    chk("unwind_emp", 32'(fa.empStck), 1);
    chk("unwind_full", 32'(fa.full), 0);
    // push + pop on empty performs the push only
    do_reset();
    step(1, 1, 0, 8'h5A);
    chk("pp_empty_count", 32'(fa.count), 1);
    chk("pp_empty_err", 32'(fa.err), 1);
    chk("pp_empty_valid", 32'(fa.outValid), 0);
    step(0, 1, 0, 8'h00);
    chk("pp_empty_pop", 32'(fa.locOut), 32'h5A);
    // push while draining is dropped
    do_reset();
    step(1, 0, 0, 8'h05);
    step(1, 0, 0, 8'h06);
    step(0, 0, 1, 8'h00);
    step(1, 0, 0, 8'h07);
    chk("drain_push_err", 32'(fa.err), 1);
    chk("drain_push_cnt", 32'(fa.count), 2);
    chk("drain_push_st", 32'(fa.draining), 1);
    // asynchronous reset mid-drain
    do_reset();
    step(1, 0, 0, 8'h0A);
    step(1, 0, 0, 8'h0B);
    step(1, 0, 0, 8'h0C);
    step(0, 0, 1, 8'h00);
    step(0, 1, 0, 8'h00);
    chk("pre_rst_loc", 32'(fa.locOut), 32'h0A);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_count", 32'(fa.count), 0);
    chk("arst_emp", 32'(fa.empStck), 1);
    chk("arst_drain", 32'(fa.draining), 0);
    chk("arst_loc", 32'(fa.locOut), 0);
    chk("arst_err", 32'(fa.err), 0);
    step(1, 0, 0, 8'h99);
    chk("rst_hold_push", 32'(fa.count), 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_emp", 32'(lb.empStck), 1);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
